// File: rtl/nec_stack_sequencer_pkg.sv
// nec_stack_sequencer_pkg
//    Shared types and constants for the stack sequencer.
//    - stack_seq_state_e : sequencer FSM states.
//    - scan_dir_e        : scan direction of the mask priority encoder.
//    - STACK_*           : bit assignments of the decoder push/pop masks.
package nec_stack_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PUSH = 2'd1,
      ST_POP  = 2'd2,
      ST_DONE = 2'd3
   } stack_seq_state_e;

   typedef enum logic {
      SCAN_LSB_FIRST = 1'b0,
      SCAN_MSB_FIRST = 1'b1
   } scan_dir_e;

   // Mask bit assignments (bit index == register-file select)
   localparam logic [3:0] STACK_AW   = 4'd0;
   localparam logic [3:0] STACK_CW   = 4'd1;
   localparam logic [3:0] STACK_DW   = 4'd2;
   localparam logic [3:0] STACK_BW   = 4'd3;
   localparam logic [3:0] STACK_SP   = 4'd4;   // push stores the SP at start; pop discards
   localparam logic [3:0] STACK_SKIP = 4'd5;   // push ignores; pop reads and discards
   localparam logic [3:0] STACK_BP   = 4'd6;
   localparam logic [3:0] STACK_IX   = 4'd7;
   localparam logic [3:0] STACK_IY   = 4'd8;
   localparam logic [3:0] STACK_PSW  = 4'd10;
   localparam logic [3:0] STACK_PS   = 4'd11;
   localparam logic [3:0] STACK_PC   = 4'd14;
   localparam logic [3:0] STACK_OPND = 4'd15;  // register file returns the operand bus

endpackage

// File: rtl/nec_stack_sequencer_scan.sv
// nec_stack_mask_scan
//    Combinational priority encoder over a 16-bit slot mask.
//    DIR = SCAN_LSB_FIRST picks the lowest set bit, SCAN_MSB_FIRST the highest.
//    Ports:
//       mask  in  16 : slot mask
//       any   out  1 : at least one bit set
//       index out  4 : selected bit (0 when mask is empty)
module nec_stack_mask_scan
   import nec_stack_sequencer_pkg::*;
#(
   parameter scan_dir_e DIR = SCAN_LSB_FIRST
) (
   input  logic [15:0] mask,
   output logic        any,
   output logic [3:0]  index
);

   always_comb begin
      any   = |mask;
      index = 4'd0;
      // The last matching assignment wins, so iterate toward the preferred end.
      if (DIR == SCAN_LSB_FIRST) begin
         for (int i = 15; i >= 0; i--) begin
            if (mask[i]) index = 4'(i);
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (mask[i]) index = 4'(i);
         end
      end
   end

endmodule

// File: rtl/nec_stack_sequencer.sv
// nec_stack_sequencer
//    Walks the decoder push/pop masks, issuing one stack bus cycle per set bit.
//    Pushes (lowest bit first) pre-decrement SP and write; pops (highest bit
//    first) read and post-increment SP. All pushes finish before any pop.
//    Ports:
//       clk, reset_n            : clock, synchronous active-low reset
//       start, push_mask,
//       pop_mask, sp_in         : sequence request (sampled in IDLE only)
//       busy, done              : status; done is a one-cycle completion pulse
//       reg_rd_sel/reg_rd_data  : register-file read for the current push slot
//       reg_wr_en/sel/data      : pop writeback, one cycle after the ack
//       mem_req/wr/addr/wdata,
//       mem_ack/rdata           : BIU handshake, SS-relative addresses
//       sp_out, sp_we           : final SP, committed together with done
module nec_stack_sequencer
   import nec_stack_sequencer_pkg::*;
#(
   parameter int WORD_BYTES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] push_mask,
   input  logic [15:0] pop_mask,
   input  logic [15:0] sp_in,
   output logic        busy,
   output logic        done,
   output logic [3:0]  reg_rd_sel,
   input  logic [15:0] reg_rd_data,
   output logic        reg_wr_en,
   output logic [3:0]  reg_wr_sel,
   output logic [15:0] reg_wr_data,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] sp_out,
   output logic        sp_we
);

   localparam logic [15:0] STEP      = 16'(WORD_BYTES);
   localparam logic [15:0] SKIP_MASK = 16'h0001 << STACK_SKIP;

   stack_seq_state_e state_q;
   logic [15:0] push_q, pop_q, sp_q, orig_sp_q;
   logic        busy_q, done_q, sp_we_q;
   logic        mem_req_q, mem_wr_q;
   logic [15:0] mem_addr_q, sp_out_q;
   logic        reg_wr_en_q;
   logic [3:0]  reg_wr_sel_q;
   logic [15:0] reg_wr_data_q;

   logic        push_any, pop_any;
   logic [3:0]  push_idx, pop_idx;
   logic [15:0] push_clr_d, pop_clr_d, sp_dec_d, sp_inc_d, push_start_d;

   nec_stack_mask_scan #(.DIR(SCAN_LSB_FIRST)) u_push_scan (
      .mask  (push_q),
      .any   (push_any),
      .index (push_idx)
   );

   nec_stack_mask_scan #(.DIR(SCAN_MSB_FIRST)) u_pop_scan (
      .mask  (pop_q),
      .any   (pop_any),
      .index (pop_idx)
   );

   // Bit 5 never produces a push cycle, so it is dropped when the mask is latched.
   assign push_start_d = push_mask & ~SKIP_MASK;
   assign push_clr_d   = push_q & ~(16'h0001 << push_idx);
   assign pop_clr_d    = pop_q  & ~(16'h0001 << pop_idx);
   assign sp_dec_d     = sp_q - STEP;
   assign sp_inc_d     = sp_q + STEP;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         push_q        <= '0;
         pop_q         <= '0;
         sp_q          <= '0;
         orig_sp_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         sp_we_q       <= 1'b0;
         sp_out_q      <= '0;
         mem_req_q     <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_addr_q    <= '0;
         reg_wr_en_q   <= 1'b0;
         reg_wr_sel_q  <= '0;
         reg_wr_data_q <= '0;
      end else begin
         done_q      <= 1'b0;
         sp_we_q     <= 1'b0;
         reg_wr_en_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  push_q    <= push_start_d;
                  pop_q     <= pop_mask;
                  sp_q      <= sp_in;
                  orig_sp_q <= sp_in;
                  busy_q    <= 1'b1;
                  if (push_start_d != '0) begin
                     state_q    <= ST_PUSH;
                     mem_req_q  <= 1'b1;
                     mem_wr_q   <= 1'b1;
                     mem_addr_q <= sp_in - STEP;
                  end else if (pop_mask != '0) begin
                     state_q    <= ST_POP;
                     mem_req_q  <= 1'b1;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= sp_in;
                  end else begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     sp_we_q  <= 1'b1;
                     sp_out_q <= sp_in;
                  end
               end
            end
            ST_PUSH: begin
               if (mem_ack && push_any) begin
                  push_q <= push_clr_d;
                  sp_q   <= sp_dec_d;
                  if (push_clr_d != '0) begin
                     mem_addr_q <= sp_dec_d - STEP;
                  end else if (pop_any) begin
                     state_q    <= ST_POP;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= sp_dec_d;
                  end else begin
                     state_q    <= ST_DONE;
                     mem_req_q  <= 1'b0;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= '0;
                     done_q     <= 1'b1;
                     sp_we_q    <= 1'b1;
                     sp_out_q   <= sp_dec_d;
                  end
               end
            end
            ST_POP: begin
               if (mem_ack && pop_any) begin
                  pop_q         <= pop_clr_d;
                  sp_q          <= sp_inc_d;
                  // SP and the bit-5 slot are read but never written back.
                  reg_wr_en_q   <= (pop_idx != STACK_SP) && (pop_idx != STACK_SKIP);
                  reg_wr_sel_q  <= pop_idx;
                  reg_wr_data_q <= mem_rdata;
                  if (pop_clr_d != '0) begin
                     mem_addr_q <= sp_inc_d;
                  end else begin
                     state_q    <= ST_DONE;
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= '0;
                     done_q     <= 1'b1;
                     sp_we_q    <= 1'b1;
                     sp_out_q   <= sp_inc_d;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign sp_we       = sp_we_q;
   assign sp_out      = sp_out_q;
   assign mem_req     = mem_req_q;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = mem_addr_q;
   assign reg_wr_en   = reg_wr_en_q;
   assign reg_wr_sel  = reg_wr_sel_q;
   assign reg_wr_data = reg_wr_data_q;

   // Push data comes straight from the register file read port for the current slot.
   assign reg_rd_sel = (state_q == ST_PUSH) ? push_idx : 4'd0;
   assign mem_wdata  = (state_q != ST_PUSH)   ? 16'h0000  :
                       (push_idx == STACK_SP) ? orig_sp_q : reg_rd_data;

endmodule

// File: tb/tb_nec_stack_sequencer.sv
module tb_nec_stack_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] push_mask, pop_mask, sp_in;
   logic        busy, done;
   logic [3:0]  reg_rd_sel;
   logic [15:0] reg_rd_data;
   logic        reg_wr_en;
   logic [3:0]  reg_wr_sel;
   logic [15:0] reg_wr_data;
   logic        mem_req, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] sp_out;
   logic        sp_we;

   nec_stack_sequencer #(.WORD_BYTES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .push_mask   (push_mask),
      .pop_mask    (pop_mask),
      .sp_in       (sp_in),
      .busy        (busy),
      .done        (done),
      .reg_rd_sel  (reg_rd_sel),
      .reg_rd_data (reg_rd_data),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_sel  (reg_wr_sel),
      .reg_wr_data (reg_wr_data),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .sp_out      (sp_out),
      .sp_we       (sp_we)
   );

   always #5 clk = ~clk;

   // Bench-side register file and stack memory
   logic [15:0] regs [0:15];
   logic [15:0] mem  [0:65535];
   logic [15:0] mm   [0:65535];   // model's private copy of memory
   assign reg_rd_data = regs[reg_rd_sel];

   typedef struct packed {
      logic        wr;
      logic [3:0]  sel;
      logic [15:0] addr;
      logic [15:0] data;
   } bus_t;
   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] data;
   } wb_t;

   bus_t exp_bus [$];
   wb_t  exp_wb  [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Stack model: walk the masks in architectural order with plain arithmetic.
   task automatic build_model(input logic [15:0] pm, input logic [15:0] qm,
                              input logic [15:0] sp0, output logic [15:0] sp_fin);
      logic [15:0] s, d;
      exp_bus.delete();
      exp_wb.delete();
      mm = mem;
      s = sp0;
      for (int b = 0; b < 16; b++) begin
         if (pm[b] && b != 5) begin
            s = s - 16'd2;
            d = (b == 4) ? sp0 : regs[b];
            exp_bus.push_back({1'b1, 4'(b), s, d});
            mm[s] = d;
         end
      end
      for (int b = 15; b >= 0; b--) begin
         if (qm[b]) begin
            exp_bus.push_back({1'b0, 4'(b), s, 16'h0000});
            if (b != 4 && b != 5) exp_wb.push_back({4'(b), mm[s]});
            s = s + 16'd2;
         end
      end
      sp_fin = s;
   endtask

   task automatic run_seq(input logic [15:0] pm, input logic [15:0] qm,
                          input logic [15:0] sp0, input int fixlat, input bit noise);
      logic [15:0] exp_sp;
      bus_t e;
      wb_t  w;
      int   cyc, lat, lat_sum, wcnt;
      bit   seen_done;
      build_model(pm, qm, sp0, exp_sp);
      start = 1'b1; push_mask = pm; pop_mask = qm; sp_in = sp0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; lat_sum = 0; wcnt = 0; seen_done = 1'b0;
      lat = (fixlat > 0) ? fixlat : $urandom_range(1, 4);
      while (cyc < 400) begin
         if (reg_wr_en) begin
            if (exp_wb.size() == 0) check_eq("wb_extra", 16'd1, 16'd0);
            else begin
               w = exp_wb.pop_front();
               check_eq("wb_sel", 16'(reg_wr_sel), 16'(w.sel));
               check_eq("wb_data", reg_wr_data, w.data);
            end
         end
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         mem_ack = 1'b0;
         mem_rdata = 16'($urandom);
         if (mem_req) begin
            if (exp_bus.size() == 0) begin
               check_eq("bus_extra", 16'd1, 16'd0);
               break;
            end
            e = exp_bus[0];
            check_eq("mem_wr", 16'(mem_wr), 16'(e.wr));
            check_eq("mem_addr", mem_addr, e.addr);
            if (e.wr) begin
               check_eq("mem_wdata", mem_wdata, e.data);
               check_eq("reg_rd_sel", 16'(reg_rd_sel), 16'(e.sel));
            end
            wcnt++;
            if (wcnt >= lat) begin
               mem_ack = 1'b1;
               if (e.wr) mem[e.addr] = e.data;
               else      mem_rdata = mem[e.addr];
               void'(exp_bus.pop_front());
               lat_sum += lat;
               wcnt = 0;
               lat = (fixlat > 0) ? fixlat : $urandom_range(1, 4);
            end
         end
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            push_mask = 16'($urandom);
            pop_mask = 16'($urandom);
            sp_in = 16'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      mem_ack = 1'b0;
      check_eq("done_seen", 16'(seen_done), 16'd1);
      check_eq("done_cycle", 16'(cyc), 16'(1 + lat_sum));
      check_eq("sp_we", 16'(sp_we), 16'd1);
      check_eq("sp_out", sp_out, exp_sp);
      check_eq("bus_left", 16'(exp_bus.size()), 16'd0);
      check_eq("wb_left", 16'(exp_wb.size()), 16'd0);
      $display("txn push=%h pop=%h sp=%h -> sp_out=%h done_cycle=%0d", pm, qm, sp0, sp_out, cyc);
      @(negedge clk);
      check_eq("done_pulse", 16'(done), 16'd0);
      check_eq("busy_idle", 16'(busy), 16'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, 16'(busy), 16'd0);
      check_eq({tag, "_done"}, 16'(done), 16'd0);
      check_eq({tag, "_mem_req"}, 16'(mem_req), 16'd0);
      check_eq({tag, "_mem_wr"}, 16'(mem_wr), 16'd0);
      check_eq({tag, "_reg_wr_en"}, 16'(reg_wr_en), 16'd0);
      check_eq({tag, "_sp_we"}, 16'(sp_we), 16'd0);
   endtask

   initial begin
      logic [15:0] pm, qm;
      reset_n = 1'b0; start = 1'b0; push_mask = '0; pop_mask = '0; sp_in = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
      regs[0] = 16'h1234;
      repeat (3) @(negedge clk);
      check_idle_outputs("rst");
      check_eq("rst_mem_addr", mem_addr, 16'h0000);
      check_eq("rst_mem_wdata", mem_wdata, 16'h0000);
      check_eq("rst_wr_sel", 16'(reg_wr_sel), 16'h0000);
      check_eq("rst_wr_data", reg_wr_data, 16'h0000);
      check_eq("rst_sp_out", sp_out, 16'h0000);
      check_eq("rst_rd_sel", 16'(reg_rd_sel), 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);

      run_seq(16'h0001, 16'h0000, 16'h0100, 1, 1'b0);   // PUSH AW
      run_seq(16'h01FF, 16'h0000, 16'h2000, 1, 1'b0);   // PUSH R
      run_seq(16'h0000, 16'h01EF, 16'h1FF0, 1, 1'b0);   // POP R
      run_seq(16'h4C00, 16'h0000, 16'h0000, 1, 1'b0);   // interrupt entry, wraps
      run_seq(16'h0000, 16'h4C00, 16'hFFFA, 3, 1'b0);   // RETI, wraps to 0
      run_seq(16'h0000, 16'h0000, 16'h5A5A, 1, 1'b0);   // empty masks
      run_seq(16'h0020, 16'h0030, 16'h0002, 2, 1'b1);   // bit 5 push-only, pop bits 4/5
      run_seq(16'h8013, 16'hC111, 16'h0004, 0, 1'b1);   // both masks, wrap

      // Reset during the second slot's wait: the sequence is abandoned.
      start = 1'b1; push_mask = 16'h01FF; pop_mask = 16'h0000; sp_in = 16'h3000;
      @(negedge clk);                          // cycle 1: slot 1 request
      start = 1'b0;
      @(negedge clk);                          // cycle 2
      mem_ack = 1'b1;
      mem[16'h2FFE] = regs[0];
      @(negedge clk);                          // cycle 3: slot 2 request
      mem_ack = 1'b0;
      check_eq("rst_mid_req", 16'(mem_req), 16'd1);
      check_eq("rst_mid_addr", mem_addr, 16'h2FFC);
      @(negedge clk);                          // cycle 4: still waiting
      reset_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_mid");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("rst_after");

      for (int t = 0; t < 40; t++) begin
         pm = 16'($urandom);
         qm = 16'($urandom);
         if ($urandom_range(0, 3) == 0) pm = 16'h0000;
         if ($urandom_range(0, 3) == 0) qm = 16'h0000;
         if ($urandom_range(0, 2) == 0) begin
            pm = pm & 16'($urandom);
            qm = qm & 16'($urandom);
         end
         run_seq(pm, qm, 16'($urandom), 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nec_stack_sequencer.md
# nec_stack_sequencer

Executes the stack traffic described by the decoder's `push` and `pop` bitmasks: one memory word per set bit, SP adjusted per slot, register file read for pushes and written for pops. Sits between the execute stage and the bus interface unit. Serves PUSH/POP, PUSH R/POP R, CALL/RET, interrupt entry and RETI. Addresses are SS-relative offsets; the BIU applies the segment.

## Interface
- `WORD_BYTES`, default 2: SP step per slot, in bytes.
- `clk`  in  1: clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: begin sequence. Sampled only in IDLE.
- `push_mask`  in  16: decoder `push` field, using the STACK_* bit assignments.
- `pop_mask`  in  16: decoder `pop` field.
- `sp_in`  in  16: SP value at start.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the sequence completes.
- `reg_rd_sel`  out  4: bit index of the current push slot; combinational register-file read select.
- `reg_rd_data`  in  16: value for `reg_rd_sel`. Bit 15 selects the operand bus.
- `reg_wr_en`  out  1: pop writeback strobe.
- `reg_wr_sel`  out  4: pop writeback bit index.
- `reg_wr_data`  out  16: pop writeback data.
- `mem_req`  out  1: bus request, held until acknowledged.
- `mem_wr`  out  1: 1 = write (push), 0 = read (pop).
- `mem_addr`  out  16: SS offset.
- `mem_wdata`  out  16: push data.
- `mem_ack`  in  1: request completes in the cycle this is seen high with `mem_req`.
- `mem_rdata`  in  16: pop data, valid with `mem_ack`.
- `sp_out`  out  16: final SP.
- `sp_we`  out  1: SP commit pulse, coincident with `done`.

## Operation
- **States:** IDLE, PUSH, POP, DONE.
- **Start:** on `start` in IDLE, latch both masks and `sp_in` into `sp_r`. Set `orig_sp = sp_in`.
  - Push mask nonzero: go to PUSH.
  - Else pop mask nonzero: go to POP.
  - Else: go to DONE.
- **PUSH slot order:** lowest set bit first (0→15), so AW is stored at the highest address.
- **PUSH slot behaviour:**
  - `mem_addr = sp_r - WORD_BYTES`.
  - `mem_wdata = reg_rd_data`. Exception: bit 4 (STACK_SP) writes `orig_sp`.
  - On ack: `sp_r -= WORD_BYTES` and clear the bit.
- **PUSH exit:** when the push mask is empty, go to POP if pops remain, else DONE.
- **PUSH bit 5:** ignored (cleared without a bus cycle).
- **POP slot order:** highest set bit first (15→0).
- **POP slot behaviour:**
  - `mem_addr = sp_r`, `mem_wr = 0`.
  - On ack: `reg_wr_en = 1`, `reg_wr_sel = bit`, `reg_wr_data = mem_rdata`, `sp_r += WORD_BYTES`, clear the bit.
- **POP bits 4 and 5:** perform the read and the SP step, but suppress `reg_wr_en` (the slot is discarded). SP is only ever set via `sp_out`.
- **Both masks set:** all pushes complete before any pop.
- **DONE:** `done = 1`, `sp_we = 1`, `sp_out = sp_r`. Go to IDLE next cycle.
- **Arithmetic:** modulo 2^16. SP 0x0000 minus 2 gives 0xFFFE; no fault is raised.
- **Start while busy:** ignored; the masks are not relatched.

## Timing
- **Reset values:** state IDLE. `busy`, `done`, `mem_req`, `mem_wr`, `reg_wr_en`, `sp_we` = 0. `mem_addr`, `mem_wdata`, `reg_wr_*`, `sp_out`, `reg_rd_sel` = 0.
- **Reset mid-sequence:** IDLE on the next edge and `mem_req` drops. The outstanding BIU cycle is abandoned, with no writeback and no `sp_we`.
- **Start to first request:** `start` in cycle 0 gives `mem_req` in cycle 1.
- **Request stability:** `mem_req`, `mem_wr`, `mem_addr` and `mem_wdata` stay stable until the ack cycle. A same-cycle ack is legal.
- **Next slot:** the next slot's request appears in the cycle after an ack. With zero-wait acks, each slot costs 1 cycle.
- **Pop writeback:** `reg_wr_en` pulses in the cycle after the ack, with registered data.
- **Completion:** `done`/`sp_we` come 1 cycle after the last ack. Empty masks give `done` in cycle 1.
- **Back-to-back:** `start` is accepted again in the cycle after DONE.

## Structure
- **Shared package:** add `stack_seq_state_e` to enums.svh. The STACK_* constants stay in the package and are used for the bit-4/5/15 special cases.
- **Sub-module:** `nec_stack_mask_scan` is a combinational priority encoder with a direction parameter (LSB-first or MSB-first). It outputs `any` and `index[3:0]`; one instance serves push, one serves pop.

## Test plan
- **PUSH AW:** mask 0x0001, SP 0x0100, AW 0x1234, zero-wait ack → write 0x1234 @0x00FE. `done` in cycle 2, `sp_out` 0x00FE.
- **PUSH R:** mask 0x01FF, SP 0x2000 → 8 writes, AW@0x1FFE down to IY@0x1FF0. The SP slot is 0x2000 @0x1FF6. `sp_out` 0x1FF0.
- **POP R:** mask 0x01EF, SP 0x1FF0 → 8 reads ascending from 0x1FF0. No writeback at the 0x1FF6 slot. `sp_out` 0x2000.
- **RETI:** mask 0x4C00, SP 0xFFFA, ack delayed 3 cycles per slot → writeback order PC, PS, PSW. `sp_out` 0x0000 (wrap); `done` at cycle 1 + 3×3.
- **Interrupt entry:** push 0x4C00 from SP 0x0000 → addresses 0xFFFE, 0xFFFC, 0xFFFA (PSW, PS, PC).
- **Reset and empty masks:**
  - `reset_n` low during the 2nd slot's wait → `mem_req` low next cycle, no `sp_we`, `busy` 0.
  - Empty masks → `done` in cycle 1 with `sp_out == sp_in`.
